// File: rtl/timer_irq_pkg.sv
// timer_irq_pkg
//   Shared constants and types for the timer interrupt controller:
//   register word indices (PADDR[4:2]), interrupt source indices and
//   the decoded APB request bundle used inside timer_irq_ctrl.
package timer_irq_pkg;

  localparam int NUM_SRC = 2;
  localparam int SRC_OVF = 0;
  localparam int SRC_CMP = 1;

  // Word index of each register (byte offset >> 2)
  localparam logic [2:0] REG_PENDING = 3'd0;  // 0x00 RW1C
  localparam logic [2:0] REG_ENABLE  = 3'd1;  // 0x04 RW
  localparam logic [2:0] REG_CTRL    = 3'd2;  // 0x08 RW, bit0 GLOBAL_EN
  localparam logic [2:0] REG_OVF_CNT = 3'd3;  // 0x0C RO, write clears
  localparam logic [2:0] REG_CMP_CNT = 3'd4;  // 0x10 RO, write clears
  localparam logic [2:0] REG_LAST    = REG_CMP_CNT;

  // Decoded APB access for the current cycle
  typedef struct packed {
    logic       acc;  // access phase (PSEL & PENABLE)
    logic       hit;  // address maps to a register
    logic       wr;   // committing write to a mapped register
    logic       rd;   // read of a mapped register
    logic [2:0] idx;  // register word index
  } apb_req_t;

endpackage

// File: rtl/irq_edge_det.sv
// irq_edge_det
//   Rising-edge detector, one lane per bit. Each lane keeps the previous
//   sample of its input; rise is high for the single cycle in which the
//   input is 1 and the previous sample was 0, so a held level yields
//   exactly one pulse.
// Ports:
//   HCLK   - clock
//   HRESET - async active-high reset (previous samples clear to 0)
//   sig    - [W-1:0] input levels
//   rise   - [W-1:0] combinational rise pulses
module irq_edge_det #(
  parameter int W = 2
) (
  input  logic         HCLK,
  input  logic         HRESET,
  input  logic [W-1:0] sig,
  output logic [W-1:0] rise
);

  logic [W-1:0] prev_q;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) prev_q <= '0;
    else        prev_q <= sig;
  end

  assign rise = sig & ~prev_q;

endmodule

// File: rtl/timer_irq_ctrl.sv
// timer_irq_ctrl
//   APB-programmable interrupt controller for a timer with two sources
//   (overflow, compare match). Rising edges latch sticky PENDING bits and
//   bump saturating event counters; irq_o is the registered OR of enabled
//   pending bits gated by GLOBAL_EN.
// Ports:
//   HCLK, HRESET        - clock, async active-high reset
//   PADDR/PWDATA/PWRITE/PSEL/PENABLE - APB request (decode on PADDR[4:2])
//   PRDATA/PREADY/PSLVERR            - APB response (zero wait states)
//   timer_irq_i[1:0]    - [0] overflow, [1] compare match (level/pulse)
//   irq_o               - combined registered interrupt
module timer_irq_ctrl
  import timer_irq_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [NUM_SRC-1:0]        timer_irq_i,
  output logic                      irq_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  apb_req_t             req;
  logic [NUM_SRC-1:0]   rise;
  logic [NUM_SRC-1:0]   pend_q, pend_clr, en_q;
  logic                 gen_q;
  logic                 irq_q;
  logic [CNT_WIDTH-1:0] cnt_q [NUM_SRC];
  logic [31:0]          rdata;

  // ---------------- APB decode ----------------
  always_comb begin
    req     = '0;
    req.acc = PSEL & PENABLE;
    req.idx = PADDR[4:2];
    // Any address bit above [4] set, or word index past the last
    // register, is unmapped.
    req.hit = ~|PADDR[APB_ADDR_WIDTH-1:5] && (PADDR[4:2] <= REG_LAST);
    req.wr  = req.acc & PWRITE & req.hit;
    req.rd  = req.acc & ~PWRITE & req.hit;
  end

  assign PREADY  = 1'b1;
  assign PSLVERR = req.acc & ~req.hit;

  // ---------------- edge detection ----------------
  irq_edge_det #(.W(NUM_SRC)) u_edge (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .sig    (timer_irq_i),
    .rise   (rise)
  );

  // ---------------- PENDING / ENABLE / CTRL ----------------
  assign pend_clr = (req.wr && req.idx == REG_PENDING) ? PWDATA[NUM_SRC-1:0] : '0;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      pend_q <= '0;
      en_q   <= '0;
      gen_q  <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      // Set is applied after the clear so a same-cycle event wins.
      pend_q <= (pend_q & ~pend_clr) | rise;
      if (req.wr && req.idx == REG_ENABLE) en_q  <= PWDATA[NUM_SRC-1:0];
      if (req.wr && req.idx == REG_CTRL)   gen_q <= PWDATA[0];
      // Built from registered state, so a new pending bit reaches irq_o
      // one edge after it lands in PENDING.
      irq_q <= gen_q & |(pend_q & en_q);
    end
  end

  assign irq_o = irq_q;

  // ---------------- saturating event counters ----------------
  for (genvar n = 0; n < NUM_SRC; n++) begin : g_cnt
    localparam logic [2:0] CNT_REG = (n == SRC_OVF) ? REG_OVF_CNT : REG_CMP_CNT;
    logic                 clr;
    logic [CNT_WIDTH-1:0] base;

    assign clr  = req.wr && (req.idx == CNT_REG);
    // Clear first, then count: clear + event in one cycle leaves 1.
    assign base = clr ? '0 : cnt_q[n];

    always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET)              cnt_q[n] <= '0;
      else if (clr || rise[n]) cnt_q[n] <= (rise[n] && base != CNT_MAX)
                                           ? base + CNT_WIDTH'(1) : base;
    end
  end

  // ---------------- read mux ----------------
  always_comb begin
    rdata = '0;
    case (req.idx)
      REG_PENDING: rdata[NUM_SRC-1:0] = pend_q;
      REG_ENABLE:  rdata[NUM_SRC-1:0] = en_q;
      REG_CTRL:    rdata[0]           = gen_q;
      REG_OVF_CNT: rdata              = 32'(cnt_q[SRC_OVF]);
      REG_CMP_CNT: rdata              = 32'(cnt_q[SRC_CMP]);
      default:     rdata              = '0;
    endcase
  end

  assign PRDATA = req.rd ? rdata : '0;

  // Write-data bits above the register fields and byte-lane address
  // bits carry no meaning here.
  logic unused;
  assign unused = ^{PWDATA[31:NUM_SRC], PADDR[1:0]};

endmodule

// File: doc/timer_irq_ctrl.md
TIMER_IRQ_CTRL -- requirements
Module: timer_irq_ctrl

Interface
REQ-001 Parameter APB_ADDR_WIDTH, default 12: APB address width.
REQ-002 Parameter CNT_WIDTH, default 32: width of each event counter.
REQ-003 HCLK  input  1  sole clock; all state updates on rising edge.
REQ-004 HRESET  input  1  reset, asynchronous, active-high.
REQ-005 PADDR  input  APB_ADDR_WIDTH  APB address; decode uses PADDR[4:2] only.
REQ-006 PWDATA  input  32  APB write data.
REQ-007 PWRITE  input  1  APB direction; 1 = write.
REQ-008 PSEL  input  1  APB select.
REQ-009 PENABLE  input  1  APB access phase.
REQ-010 PRDATA  output  32  APB read data.
REQ-011 PREADY  output  1  APB ready; tied 1, zero wait states.
REQ-012 PSLVERR  output  1  APB error; unmapped access.
REQ-013 timer_irq_i  input  2  timer interrupts; [0] overflow, [1] compare match; level or multi-cycle pulse.
REQ-014 irq_o  output  1  combined registered interrupt to core.

Function
REQ-015 Registers: 0x00 PENDING (bits[1:0], RW1C); 0x04 ENABLE (bits[1:0], RW); 0x08 CTRL (bit0 GLOBAL_EN, RW); 0x0C OVF_CNT (RO, write clears); 0x10 CMP_CNT (RO, write clears); unused bits read 0.
REQ-016 Access: write commits when PSEL&PENABLE&PWRITE at the clock edge; read returns PRDATA combinationally while PSEL&PENABLE&~PWRITE.
REQ-017 Unmapped PADDR[4:2] (5..7) or any PADDR bit above [4] nonzero: PSLVERR=1 during access phase, PRDATA=0, no state change.
REQ-018 PRDATA=0 and PSLVERR=0 outside access phase.
REQ-019 Edge detect: per source register prev_q; event = timer_irq_i & ~prev_q; a level held high produces exactly one event.
REQ-020 Event on source n sets PENDING[n] at the same edge prev_q samples the rising input (1-cycle latency input->pending).
REQ-021 PENDING set is independent of ENABLE and GLOBAL_EN.
REQ-022 W1C: writing 1 to PENDING[n] clears it; writing 0 leaves it; event and clear in same cycle -> PENDING[n]=1 (set wins).
REQ-023 Event on source n increments its counter by 1; counter saturates at 2^CNT_WIDTH-1, never wraps.
REQ-024 Write to OVF_CNT/CMP_CNT clears it to 0 regardless of PWDATA; clear and event same cycle -> counter=1.
REQ-025 irq_o registered: next value = GLOBAL_EN & |(PENDING & ENABLE) using post-update PENDING; input rise before edge k -> irq_o=1 after edge k+1.
REQ-026 Clearing last enabled pending bit, ENABLE bit, or GLOBAL_EN drops irq_o one edge after the write.
REQ-027 Both sources rising same cycle: both PENDING bits set, both counters increment.

Reset
REQ-028 HRESET high: PENDING=0, ENABLE=0, GLOBAL_EN=0, counters=0, prev_q=0, irq_o=0, immediately without clock.
REQ-029 Reset mid-access aborts the transfer; no register update; after release, timer_irq_i already high counts as one event on the first edge.

Structure
REQ-030 Package timer_irq_pkg holds register offsets, source-index constants (SRC_OVF=0, SRC_CMP=1), source count 2.
REQ-031 One sub-module irq_edge_det (per-source prev register plus rise pulse), instantiated once with width 2.

Verification
REQ-032 Reset, ENABLE=0x3, CTRL=1, pulse timer_irq_i[1] 1 cycle -> PENDING=0x2, CMP_CNT=1, irq_o=1 two edges after rise.
REQ-033 Hold timer_irq_i[0] high 50 cycles -> OVF_CNT=1, PENDING=0x1; ENABLE=0 -> irq_o stays 0.
REQ-034 Write PENDING=0x1 on same cycle as new overflow rise -> PENDING[0] remains 1, OVF_CNT increments.
REQ-035 Force OVF_CNT to 0xFFFF_FFFF (CNT_WIDTH=32 via preload or CNT_WIDTH=4 build at 0xF), one more event -> value unchanged.
REQ-036 Read 0x14 and PADDR=0x100 -> PSLVERR=1, PRDATA=0, registers unchanged.
REQ-037 Assert HRESET mid-write to ENABLE with irq_o=1 -> irq_o=0 immediately, ENABLE reads 0 after release.
